uart_apb_completer: RTL and testbench

- APB3 completer UART peripheral: the responder end of the APB3 configuration bus that a UART requester drives.
- Serializes bytes written over APB onto tx_o as 8N1 frames.
- Deserializes 8N1 frames from rx_i into a readable data register.
- Sits on the peripheral side of the cosimulated bus; baud rate is software-set via a divisor register.

---
 rtl/renode_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_apb_completer.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_apb_completer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_pkg.sv
// Shared definitions for the APB UART completer: register offsets, STATUS bit
// positions and the bit-level state type used by both serial directions.
package renode_pkg;

  localparam int unsigned UART_DATA_OFF   = 'h0;
  localparam int unsigned UART_STATUS_OFF = 'h4;
  localparam int unsigned UART_DIV_OFF    = 'h8;

  localparam int unsigned ST_TX_EMPTY     = 0;
  localparam int unsigned ST_TX_BUSY      = 1;
  localparam int unsigned ST_RX_VALID     = 2;
  localparam int unsigned ST_RX_OVERRUN   = 3;
  localparam int unsigned ST_RX_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_bit_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero, so a load
// of N gives a tick N+1 clocks after the loading edge.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_apb_completer.sv
// APB3 completer UART: zero-wait-state register file with an 8N1 transmitter
// fed by a one-byte holding register and an 8N1 receiver with status flags.
module uart_apb_completer
  import renode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  tx_o,
  input  logic                  rx_i
);

  logic            access, sel_data, sel_status, sel_div, mapped;
  logic            wr_data_ok, rd_data, wr_status, wr_div;
  logic [15:0]     divisor;
  logic [4:0]      status_vec;

  uart_bit_state_t tx_state;
  logic [7:0]      tx_hold, tx_shift;
  logic            tx_full;
  logic [2:0]      tx_idx;
  logic            tx_load, tx_tick;

  uart_bit_state_t rx_state;
  logic            rx_s1, rx_s2, rx_prev, rx_fall;
  logic [7:0]      rx_shift, rx_data;
  logic [2:0]      rx_idx;
  logic            rx_valid, rx_overrun, rx_frame_err;
  logic            rx_load, rx_tick;
  logic [15:0]     rx_load_val;

  logic            unused_pwdata;

  assign access     = pselx & penable;
  assign sel_data   = (paddr == ADDR_WIDTH'(UART_DATA_OFF));
  assign sel_status = (paddr == ADDR_WIDTH'(UART_STATUS_OFF));
  assign sel_div    = (paddr == ADDR_WIDTH'(UART_DIV_OFF));
  assign mapped     = sel_data | sel_status | sel_div;

  assign wr_data_ok = access & pwrite & sel_data & ~tx_full;
  assign rd_data    = access & ~pwrite & sel_data;
  assign wr_status  = access & pwrite & sel_status;
  assign wr_div     = access & pwrite & sel_div;

  assign pready  = 1'b1;
  assign pslverr = access & (~mapped | (pwrite & sel_data & tx_full));
  assign unused_pwdata = ^pwdata[DATA_WIDTH-1:16];

  always_comb begin
    status_vec                  = '0;
    status_vec[ST_TX_EMPTY]     = ~tx_full;
    status_vec[ST_TX_BUSY]      = (tx_state != IDLE);
    status_vec[ST_RX_VALID]     = rx_valid;
    status_vec[ST_RX_OVERRUN]   = rx_overrun;
    status_vec[ST_RX_FRAME_ERR] = rx_frame_err;
  end

  always_comb begin
    prdata = '0;
    if (access && !pwrite) begin
      if (sel_data && rx_valid) prdata[7:0]  = rx_data;
      if (sel_status)           prdata[4:0]  = status_vec;
      if (sel_div)              prdata[15:0] = divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= 16'(DEFAULT_DIV);
    end else if (wr_div) begin
      divisor <= (pwdata[15:0] < 16'd2) ? 16'd2 : pwdata[15:0];
    end
  end

  // Timer loads are combinational so a new bit period starts on the same edge
  // as the state change; reloading from divisor applies DIVISOR writes per bit.
  assign tx_load = ((tx_state == IDLE) && tx_full) || ((tx_state != IDLE) && tx_tick);

  uart_bit_timer #(.WIDTH(16)) u_tx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (divisor - 16'd1),
    .tick     (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_o     <= 1'b1;
      tx_hold  <= '0;
      tx_full  <= 1'b0;
      tx_shift <= '0;
      tx_idx   <= '0;
    end else begin
      if (wr_data_ok) begin
        tx_hold <= pwdata[7:0];
        tx_full <= 1'b1;
      end
      case (tx_state)
        IDLE: begin
          if (tx_full) begin
            tx_shift <= tx_hold;
            tx_full  <= 1'b0;
            tx_o     <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_tick) begin
            tx_o     <= tx_shift[0];
            tx_idx   <= '0;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_tick) begin
            if (tx_idx == 3'd7) begin
              tx_o     <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_idx <= tx_idx + 3'd1;
              tx_o   <= tx_shift[tx_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (tx_tick) begin
            if (tx_full) begin
              tx_shift <= tx_hold;
              tx_full  <= 1'b0;
              tx_o     <= 1'b0;
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  assign rx_fall     = rx_prev & ~rx_s2;
  assign rx_load     = ((rx_state == IDLE) && rx_fall) ||
                       ((rx_state == START) && rx_tick && !rx_s2) ||
                       ((rx_state == DATA) && rx_tick);
  assign rx_load_val = (rx_state == IDLE) ? (divisor >> 1) : (divisor - 16'd1);

  uart_bit_timer #(.WIDTH(16)) u_rx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tick     (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= IDLE;
      rx_shift     <= '0;
      rx_idx       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rd_data) rx_valid <= 1'b0;
      if (wr_status && pwdata[ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
      if (wr_status && pwdata[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_fall) rx_state <= START;
        end
        START: begin
          if (rx_tick) begin
            rx_idx   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= STOP;
          end
        end
        STOP: begin
          // Sets follow the clears above so a simultaneous set wins.
          if (rx_tick) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rd_data) rx_overrun   <= 1'b1;
            if (!rx_s2)               rx_frame_err <= 1'b1;
            rx_state <= IDLE;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_completer.sv
// Directed bench for uart_apb_completer with a frame-timeline model of TX and a
// transaction-level model of RX and the register file.
module tb_uart_apb_completer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  paddr = '0;
  logic        pselx = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready, pslverr, tx_o;
  logic [31:0] prdata;
  logic        rx_i = 1'b1;

  uart_apb_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEFAULT_DIV(16)) dut (
    .clk(clk), .rst(rst), .paddr(paddr), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .tx_o(tx_o), .rx_i(rx_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  bit checking = 1'b0;

  // TX model: each accepted byte becomes a frame with commit edge c, start
  // edge s and bit length d; line level is derived from elapsed time.
  typedef struct { int c; int s; int d; logic [7:0] b; } frame_t;
  frame_t frames[$];
  int          div_m = 16;
  logic        rxv_m = 1'b0, ovr_m = 1'b0, fer_m = 1'b0;
  logic [7:0]  rxd_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_tx(input int t);
    foreach (frames[i]) begin
      if (t >= frames[i].s && t < frames[i].s + 10 * frames[i].d) begin
        int k;
        k = (t - frames[i].s) / frames[i].d;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return frames[i].b[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit hold_full(input int t);
    foreach (frames[i]) if (frames[i].c <= t && t < frames[i].s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit tx_busy_m(input int t);
    foreach (frames[i])
      if (frames[i].s <= t && t < frames[i].s + 10 * frames[i].d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(input int t);
    return {27'd0, fer_m, ovr_m, rxv_m, tx_busy_m(t), ~hold_full(t)};
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      chk("tx_o", 32'(tx_o), 32'(model_tx(cyc)));
      chk("pready", 32'(pready), 32'd1);
      if (!(pselx && penable)) begin
        chk("prdata_idle", prdata, 32'd0);
        chk("pslverr_idle", 32'(pslverr), 32'd0);
      end
    end
  end

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int commit);
    @(posedge clk); #1;
    paddr = a; pwrite = wr; pwdata = wd; pselx = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    commit = cyc; pselx = 1'b0; penable = 1'b0;
  endtask

  task automatic do_write(input string name, input logic [7:0] a, input logic [31:0] wd,
                          output logic err, output int n);
    logic [31:0] rd;
    bit exp_err;
    frame_t f;
    apb(1'b1, a, wd, rd, err, n);
    if (a == 8'h0)                    exp_err = hold_full(n - 1);
    else if (a == 8'h4 || a == 8'h8)  exp_err = 1'b0;
    else                              exp_err = 1'b1;
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    if (!exp_err) begin
      if (a == 8'h0) begin
        f.c = n; f.d = div_m; f.b = wd[7:0]; f.s = n + 1;
        if (frames.size() > 0 && frames[$].s + 10 * frames[$].d > f.s)
          f.s = frames[$].s + 10 * frames[$].d;
        frames.push_back(f);
      end else if (a == 8'h4) begin
        if (wd[3]) ovr_m = 1'b0;
        if (wd[4]) fer_m = 1'b0;
      end else begin
        div_m = (wd[15:0] < 16'd2) ? 2 : int'(wd[15:0]);
      end
    end
  endtask

  task automatic do_read(input string name, input logic [7:0] a, output logic [31:0] rd);
    logic err;
    int n;
    logic [31:0] exp_rd;
    bit exp_err;
    apb(1'b0, a, 32'd0, rd, err, n);
    exp_err = !(a == 8'h0 || a == 8'h4 || a == 8'h8);
    exp_rd  = 32'd0;
    if (a == 8'h0)      exp_rd = rxv_m ? {24'd0, rxd_m} : 32'd0;
    else if (a == 8'h4) exp_rd = model_status(n - 1);
    else if (a == 8'h8) exp_rd = 32'(div_m);
    chk({name, "_data"}, rd, exp_rd);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    if (a == 8'h0) rxv_m = 1'b0;
  endtask

  task automatic wait_until(input int e);
    @(negedge clk);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic tx_at(input string name, input int e, input logic exp);
    wait_until(e);
    chk(name, 32'(tx_o), 32'(exp));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rx_i = fr[i];
      repeat (div_m - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    rx_i = 1'b1;
    repeat (2 * div_m) @(posedge clk);
    if (rxv_m) ovr_m = 1'b1;
    rxv_m = 1'b1;
    rxd_m = b;
    if (!stopb) fer_m = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          n, s1;
    logic [9:0]  pat55;

    repeat (1) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_o", 32'(tx_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;

    do_read("reset_status", 8'h4, rd);
    chk("reset_status_lit", rd, 32'h1);
    do_read("reset_div", 8'h8, rd);
    chk("reset_div_lit", rd, 32'd16);
    do_read("empty_data", 8'h0, rd);

    do_write("div_small", 8'h8, 32'd1, err, n);
    do_read("div_clamped", 8'h8, rd);
    chk("div_clamped_lit", rd, 32'd2);
    do_write("div4", 8'h8, 32'd4, err, n);

    // Single frame 0x55: start, LSB-first data, stop; 4 clocks each.
    pat55 = 10'b1_0101_0101_0;
    do_write("tx55", 8'h0, 32'h55, err, n);
    s1 = n + 1;
    tx_at("tx55_bit0", s1, 1'b0);
    do_read("tx55_status_busy", 8'h4, rd);
    chk("tx55_status_busy_lit", rd, 32'h3);
    for (int k = 1; k < 10; k++) tx_at($sformatf("tx55_slot%0d", k), s1 + 4 * k + 1, pat55[k]);
    wait_until(s1 + 40);
    do_read("tx55_status_done", 8'h4, rd);
    chk("tx55_status_done_lit", rd, 32'h1);

    // Back-to-back frames with a third write rejected while holding is full.
    do_write("b2b_a1", 8'h0, 32'hA1, err, n);
    s1 = n + 1;
    do_write("b2b_3c", 8'h0, 32'h3C, err, n);
    do_read("b2b_status", 8'h4, rd);
    chk("b2b_status_lit", rd, 32'h2);
    do_write("b2b_third", 8'h0, 32'hFF, err, n);
    chk("b2b_third_err_lit", 32'(err), 32'd1);
    tx_at("b2b_stop1", s1 + 39, 1'b1);
    tx_at("b2b_start2", s1 + 40, 1'b0);
    wait_until(s1 + 81);
    do_read("b2b_status_done", 8'h4, rd);
    chk("b2b_status_done_lit", rd, 32'h1);

    // Receive path at DIVISOR=8.
    do_write("div8", 8'h8, 32'd8, err, n);
    send_rx(8'hC3, 1'b1);
    do_read("rx_c3_status", 8'h4, rd);
    chk("rx_c3_status_lit", rd, 32'h5);
    do_read("rx_c3_data", 8'h0, rd);
    chk("rx_c3_data_lit", rd, 32'hC3);
    do_read("rx_c3_status2", 8'h4, rd);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    do_read("ovr_status", 8'h4, rd);
    chk("ovr_status_lit", rd, 32'hD);
    do_read("ovr_data", 8'h0, rd);
    chk("ovr_data_lit", rd, 32'h22);

    send_rx(8'h5A, 1'b0);
    do_read("ferr_status", 8'h4, rd);
    chk("ferr_status_lit", rd, 32'h1D);
    do_write("w1c", 8'h4, 32'h18, err, n);
    do_read("w1c_status", 8'h4, rd);
    chk("w1c_status_lit", rd, 32'h5);
    do_read("ferr_data", 8'h0, rd);
    chk("ferr_data_lit", rd, 32'h5A);

    // Short low glitch must be rejected as a false start.
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (30) @(posedge clk);
    do_read("glitch_status", 8'h4, rd);
    chk("glitch_status_lit", rd, 32'h1);

    // Misaligned and unmapped accesses.
    do_write("misaligned_wr", 8'h2, 32'h77, err, n);
    chk("misaligned_wr_err_lit", 32'(err), 32'd1);
    do_read("misaligned_status", 8'h4, rd);
    chk("misaligned_status_lit", rd, 32'h1);
    do_read("unmapped_rd", 8'hC, rd);
    do_write("unmapped_wr", 8'hC, 32'd3, err, n);
    do_read("div_unchanged", 8'h8, rd);
    chk("div_unchanged_lit", rd, 32'd8);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
